// File: rtl/fp_div_post.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_post
// Brief    : Single-precision divider post-stage. Handles IEEE special cases
//            and exponent range, then queues results in order under credit flow.
// Revision : 1.0 - initial release
// ============================================================================
module fp_div_post #(
    parameter int DIV_LAT = 1,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] q_raw,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_LAST  = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic       valid;
        logic       sign;
        logic       a_zero;
        logic       a_inf;
        logic       a_nan;
        logic       b_zero;
        logic       b_inf;
        logic       b_nan;
        logic [9:0] e_est;
    } meta_t;

    logic             issue;
    logic             push;
    logic             pop;
    meta_t            meta_in;
    meta_t            dl_q [DIV_LAT];
    meta_t            m;
    logic [1:0]       adj;
    logic [9:0]       e_fin;
    logic [31:0]      fin_result;
    logic [3:0]       fin_flags;
    logic [35:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] credit_q, credit_d;

    assign in_ready  = (credit_q < c_DEPTH_CNT);
    assign issue     = in_valid && in_ready;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    // Operand classification; denormals count as zero.
    always_comb begin
        meta_in        = '0;
        meta_in.valid  = issue;
        meta_in.sign   = a[31] ^ b[31];
        meta_in.a_zero = (a[30:23] == 8'd0);
        meta_in.a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        meta_in.a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        meta_in.b_zero = (b[30:23] == 8'd0);
        meta_in.b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        meta_in.b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        meta_in.e_est  = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIV_LAT; i++) dl_q[i] <= '0;
        end else begin
            dl_q[0] <= meta_in;
            for (int i = 1; i < DIV_LAT; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    assign m    = dl_q[DIV_LAT-1];
    assign push = m.valid;

    // The divider wraps its exponent in 8 bits; the low two bits recover its shift.
    assign adj   = m.e_est[1:0] - q_raw[24:23];
    assign e_fin = m.e_est - {8'd0, adj};

    always_comb begin
        fin_result = q_raw;
        fin_flags  = 4'b0000;
        if (m.a_nan || m.b_nan || (m.a_zero && m.b_zero) || (m.a_inf && m.b_inf)) begin
            fin_result = 32'h7FC0_0000;
            fin_flags  = 4'b1000;
        end else if (m.b_zero && !m.a_inf) begin
            fin_result = {m.sign, 31'h7F80_0000};
            fin_flags  = 4'b0100;
        end else if (m.a_inf) begin
            fin_result = {m.sign, 31'h7F80_0000};
        end else if (m.b_inf || m.a_zero) begin
            fin_result = {m.sign, 31'd0};
        end else if ($signed(e_fin) >= 10'sd255) begin
            fin_result = {m.sign, 31'h7F80_0000};
            fin_flags  = 4'b0010;
        end else if ($signed(e_fin) <= 10'sd0) begin
            fin_result = {m.sign, 31'd0};
            fin_flags  = 4'b0001;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        credit_d = credit_q;
        if (push) wr_ptr_d = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
        if (issue && !pop)      credit_d = credit_q + CNT_W'(1);
        else if (!issue && pop) credit_d = credit_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

    // Storage needs no reset: unread slots are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {fin_flags, fin_result};
    end

    assign result = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'd0;
    assign flags  = out_valid ? mem_q[rd_ptr_q][35:32] : 4'd0;

    always_ff @(posedge clk) begin
        if (!rst) assert (credit_q <= c_DEPTH_CNT);
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_div_post.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_post
// Brief    : Directed self-checking bench for fp_div_post with a 1-cycle divider model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_div_post;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] q_raw = '0;
    logic [31:0] q_next = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    fp_div_post #(.DIV_LAT(1), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .q_raw     (q_raw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Divider model: registers its quotient once.
    always @(posedge clk) q_raw <= q_next;

    localparam int NV = 16;
    logic [31:0] tv_a   [NV] = '{32'h4000_0000, 32'h7F00_0000, 32'h80800000, 32'h7F80_0000,
                                 32'h7F40_0000, 32'h7F00_0000, 32'h0080_0000, 32'h0080_0000,
                                 32'h0080_0000, 32'h0000_0001, 32'h3F80_0000, 32'h7FC0_0000,
                                 32'h7F80_0000, 32'h7F80_0000, 32'h8000_0000, 32'h3F80_0000};
    logic [31:0] tv_b   [NV] = '{32'h3F80_0000, 32'h0080_0000, 32'h7F00_0000, 32'hC000_0000,
                                 32'h3F00_0000, 32'h3FC0_0000, 32'h3F80_0000, 32'h3FC0_0000,
                                 32'h4040_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000,
                                 32'h7F80_0000, 32'h0000_0000, 32'h40A0_0000, 32'h3FC0_0000};
    logic [31:0] tv_q   [NV] = '{32'h4000_0000, 32'h7E00_0000, 32'hC100_0000, 32'h0000_0000,
                                 32'h7FC0_0000, 32'h7EAA_AAAB, 32'h0080_0000, 32'h002A_AAAB,
                                 32'h7FAA_AAAB, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                                 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F2A_AAAB};
    logic [31:0] tv_res [NV] = '{32'h4000_0000, 32'h7F80_0000, 32'h8000_0000, 32'hFF80_0000,
                                 32'h7F80_0000, 32'h7EAA_AAAB, 32'h0080_0000, 32'h0000_0000,
                                 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000,
                                 32'h7FC0_0000, 32'h7F80_0000, 32'h8000_0000, 32'h3F2A_AAAB};
    logic [3:0]  tv_flg [NV] = '{4'b0000, 4'b0010, 4'b0001, 4'b0000,
                                 4'b0010, 4'b0000, 4'b0000, 4'b0001,
                                 4'b0001, 4'b0000, 4'b0000, 4'b1000,
                                 4'b1000, 4'b0000, 4'b0000, 4'b0000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vq);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        q_next   = vq;
        tick();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        q_next   = '0;
    endtask

    // Wait (bounded) for the head entry, compare it, then let it pop.
    task automatic expect_out(input string tag, input logic [31:0] er, input logic [3:0] ef);
        int waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_result"}, result, er);
            check({tag, "_flags"}, {28'd0, flags}, {28'd0, ef});
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int stale;
        logic [31:0] bp_val [4];

        repeat (3) tick();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 6.0 / 2.0 with latency check
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        check("div6_2_valid_early", {31'd0, out_valid}, 32'd0);
        tick();
        check("div6_2_valid_t2", {31'd0, out_valid}, 32'd1);
        check("div6_2_result", result, 32'h4040_0000);
        check("div6_2_flags", {28'd0, flags}, 32'd0);
        tick();

        // 1/0 then 0/0 back-to-back
        issue(32'h3F80_0000, 32'h0000_0000, 32'h0000_0000);
        issue(32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        expect_out("one_div_zero", 32'h7F80_0000, 4'b0100);
        expect_out("zero_div_zero", 32'h7FC0_0000, 4'b1000);

        for (int i = 0; i < NV; i++) begin
            issue(tv_a[i], tv_b[i], tv_q[i]);
            expect_out($sformatf("vec%0d", i), tv_res[i], tv_flg[i]);
        end

        // Back-pressure: six offered, four accepted
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            a        = {1'b0, 8'(128 + k), 23'd0};
            b        = 32'h3F80_0000;
            q_next   = {1'b0, 8'(128 + k), 23'd0};
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        q_next   = '0;
        tick();
        check("bp_accepted", acc, 32'd4);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        bp_val = '{32'h4000_0000, 32'h4080_0000, 32'h4100_0000, 32'h4180_0000};
        check("bp_head", result, bp_val[0]);
        tick();
        check("bp_hold", result, bp_val[0]);
        out_ready = 1'b1;
        tick();
        check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        for (int k = 1; k < 4; k++) expect_out($sformatf("bp_drain%0d", k), bp_val[k], 4'b0000);
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset with two buffered and one in the delay line
        out_ready = 1'b0;
        repeat (3) issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            tick();
            if (out_valid) stale++;
        end
        check("mid_rst_stale", stale, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
